// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared state encoding and default widths for the memory stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int c_DATA_W  = 16;
  localparam int c_RD_W    = 3;
  localparam int c_TIMEOUT = 15;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================================
// Module : mem_timeout_ctr
// Brief  : Wait-cycle counter; flags the last permitted stalled cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_timeout_ctr
  import mem_pkg::*;
#(
  parameter int TIMEOUT = c_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Expired is raised on the stalled cycle whose increment would reach TIMEOUT.
  assign o_expired = i_en && (r_cnt == c_CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule : mem_timeout_ctr

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module : mem_stage
// Brief  : Pipeline MEM stage with data-memory handshake, timeout and MEM/WB.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W,
  parameter int RD_W    = c_RD_W,
  parameter int TIMEOUT = c_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_reg_write,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  output logic              in_ready,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic              mem_fault
);

  mem_state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_hold_addr, r_hold_wdata;
  logic [RD_W-1:0]   r_hold_rd;
  logic              r_hold_write, r_hold_reg_write;

  logic              r_wb_valid, r_wb_reg_write, r_wb_mem_to_reg, r_fault;
  logic [RD_W-1:0]   r_wb_rd;
  logic [DATA_W-1:0] r_wb_alu, r_wb_mem;

  logic              w_wait, w_expired, w_hold_ld, w_fault;
  logic              w_wb_valid, w_wb_reg_write, w_wb_mem_to_reg;
  logic [RD_W-1:0]   w_wb_rd;
  logic [DATA_W-1:0] w_wb_alu, w_wb_mem;

  assign w_wait     = (r_state == ST_WAIT);
  assign in_ready   = !w_wait;
  assign mem_stall  = w_wait;
  assign dmem_req   = w_wait;
  assign dmem_we    = w_wait && r_hold_write;
  assign dmem_addr  = w_wait ? r_hold_addr  : '0;
  assign dmem_wdata = w_wait ? r_hold_wdata : '0;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!w_wait),
    .i_en      (w_wait && !dmem_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_ld       = 1'b0;
    w_fault         = 1'b0;
    w_wb_valid      = 1'b0;
    w_wb_reg_write  = 1'b0;
    w_wb_mem_to_reg = 1'b0;
    w_wb_rd         = '0;
    w_wb_alu        = '0;
    w_wb_mem        = '0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          if (in_mem_read && in_mem_write) begin
            w_fault = 1'b1;
          end else if (in_mem_read || in_mem_write) begin
            w_hold_ld   = 1'b1;
            w_state_nxt = ST_WAIT;
          end else begin
            w_wb_valid     = 1'b1;
            w_wb_reg_write = in_reg_write;
            w_wb_rd        = in_rd;
            w_wb_alu       = in_alu_result;
          end
        end
      end
      ST_WAIT: begin
        // Completion wins over an expiring counter on the same cycle.
        if (dmem_ready) begin
          w_state_nxt     = ST_IDLE;
          w_wb_valid      = 1'b1;
          w_wb_reg_write  = r_hold_reg_write && !r_hold_write;
          w_wb_mem_to_reg = !r_hold_write;
          w_wb_rd         = r_hold_rd;
          w_wb_alu        = r_hold_addr;
          w_wb_mem        = r_hold_write ? '0 : dmem_rdata;
        end else if (w_expired) begin
          w_state_nxt = ST_IDLE;
          w_fault     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_addr      <= '0;
      r_hold_wdata     <= '0;
      r_hold_rd        <= '0;
      r_hold_write     <= 1'b0;
      r_hold_reg_write <= 1'b0;
    end else if (w_hold_ld) begin
      r_hold_addr      <= in_alu_result;
      r_hold_wdata     <= in_store_data;
      r_hold_rd        <= in_rd;
      r_hold_write     <= in_mem_write;
      r_hold_reg_write <= in_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_alu        <= '0;
      r_wb_mem        <= '0;
      r_fault         <= 1'b0;
    end else begin
      r_wb_valid      <= w_wb_valid;
      r_wb_reg_write  <= w_wb_reg_write;
      r_wb_mem_to_reg <= w_wb_mem_to_reg;
      r_wb_rd         <= w_wb_rd;
      r_wb_alu        <= w_wb_alu;
      r_wb_mem        <= w_wb_mem;
      r_fault         <= w_fault;
    end
  end

  assign wb_valid      = r_wb_valid;
  assign wb_reg_write  = r_wb_reg_write;
  assign wb_mem_to_reg = r_wb_mem_to_reg;
  assign wb_rd         = r_wb_rd;
  assign wb_alu_result = r_wb_alu;
  assign wb_mem_data   = r_wb_mem;
  assign mem_fault     = r_fault;

endmodule : mem_stage

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module : tb_mem_stage
// Brief  : Directed self-checking bench for mem_stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mem_read, in_mem_write, in_reg_write, flush;
  logic [15:0] in_alu_result, in_store_data;
  logic [2:0]  in_rd;
  logic        in_ready, mem_stall, dmem_req, dmem_we, dmem_ready;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg, mem_fault;
  logic [2:0]  wb_rd;
  logic [15:0] wb_alu_result, wb_mem_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_alu_result (in_alu_result),
    .in_store_data (in_store_data),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_reg_write  (in_reg_write),
    .in_rd         (in_rd),
    .flush         (flush),
    .in_ready      (in_ready),
    .mem_stall     (mem_stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ready    (dmem_ready),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_rd         (wb_rd),
    .wb_alu_result (wb_alu_result),
    .wb_mem_data   (wb_mem_data),
    .mem_fault     (mem_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_reg_write = 0;
    flush = 0; in_alu_result = '0; in_store_data = '0; in_rd = '0;
    dmem_ready = 0; dmem_rdata = '0;
  endtask

  task automatic issue(input logic rd_op, input logic wr_op, input logic [15:0] addr,
                       input logic [15:0] data, input logic [2:0] rd);
    in_valid = 1; in_mem_read = rd_op; in_mem_write = wr_op; in_reg_write = 1;
    in_alu_result = addr; in_store_data = data; in_rd = rd;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_fault", mem_fault, 0);
    check("rst_dmem_req", dmem_req, 0);

    // ALU pass-through
    issue(0, 0, 16'h1234, 16'h0, 3'd5);
    check("alu_in_ready", in_ready, 1);
    tick(); idle_inputs();
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_rd", wb_rd, 5);
    check("alu_wb_alu", wb_alu_result, 16'h1234);
    check("alu_mem_to_reg", wb_mem_to_reg, 0);
    check("alu_reg_write", wb_reg_write, 1);
    tick();
    check("idle_wb_valid", wb_valid, 0);
    check("idle_wb_alu_zero", wb_alu_result, 0);

    // Load with three WAIT cycles; flush during WAIT must be ignored
    issue(1, 0, 16'h0040, 16'h0, 3'd3);
    tick(); idle_inputs();
    check("ld_wb_valid_wait", wb_valid, 0);
    for (int i = 0; i < 3; i++) begin
      check("ld_dmem_req", dmem_req, 1);
      check("ld_stall", mem_stall, 1);
      check("ld_addr", dmem_addr, 16'h0040);
      check("ld_we", dmem_we, 0);
      flush = (i == 1);
      if (i == 2) begin dmem_ready = 1; dmem_rdata = 16'hBEEF; end
      tick();
    end
    idle_inputs();
    check("ld_done_req", dmem_req, 0);
    check("ld_done_ready", in_ready, 1);
    check("ld_wb_valid", wb_valid, 1);
    check("ld_wb_mem", wb_mem_data, 16'hBEEF);
    check("ld_mem_to_reg", wb_mem_to_reg, 1);
    check("ld_wb_rd", wb_rd, 3);
    check("ld_reg_write", wb_reg_write, 1);
    check("ld_wb_alu", wb_alu_result, 16'h0040);

    // Store completing in the first WAIT cycle
    issue(0, 1, 16'h0010, 16'hA5A5, 3'd2);
    tick(); idle_inputs();
    check("st_req", dmem_req, 1);
    check("st_we", dmem_we, 1);
    check("st_wdata", dmem_wdata, 16'hA5A5);
    check("st_addr", dmem_addr, 16'h0010);
    dmem_ready = 1;
    tick(); idle_inputs();
    check("st_wb_valid", wb_valid, 1);
    check("st_reg_write", wb_reg_write, 0);
    check("st_mem_to_reg", wb_mem_to_reg, 0);

    // dmem_ready in IDLE is ignored
    dmem_ready = 1; dmem_rdata = 16'h5555;
    check("idle_ready_req", dmem_req, 0);
    tick(); idle_inputs();
    check("idle_ready_wb", wb_valid, 0);
    check("idle_ready_state", in_ready, 1);

    // Timeout after 15 WAIT cycles
    issue(1, 0, 16'h0080, 16'h0, 3'd1);
    tick(); idle_inputs();
    for (int i = 0; i < 15; i++) begin
      check("to_req", dmem_req, 1);
      check("to_no_fault", mem_fault, 0);
      tick();
    end
    check("to_fault", mem_fault, 1);
    check("to_wb_valid", wb_valid, 0);
    check("to_in_ready", in_ready, 1);
    check("to_req_low", dmem_req, 0);
    tick();
    check("to_fault_pulse", mem_fault, 0);

    // Ready on the final allowed cycle completes rather than faulting
    issue(1, 0, 16'h00C0, 16'h0, 3'd6);
    tick(); idle_inputs();
    for (int i = 0; i < 14; i++) tick();
    check("edge_req", dmem_req, 1);
    dmem_ready = 1; dmem_rdata = 16'h1111;
    tick(); idle_inputs();
    check("edge_fault", mem_fault, 0);
    check("edge_wb_valid", wb_valid, 1);
    check("edge_wb_mem", wb_mem_data, 16'h1111);

    // Flush in IDLE discards both ALU and memory entries
    issue(0, 0, 16'h7777, 16'h0, 3'd4);
    flush = 1;
    tick(); idle_inputs();
    check("flush_alu_wb", wb_valid, 0);
    issue(1, 0, 16'h0020, 16'h0, 3'd4);
    flush = 1;
    tick(); idle_inputs();
    check("flush_ld_req", dmem_req, 0);
    check("flush_ld_wb", wb_valid, 0);

    // Illegal read+write
    issue(1, 1, 16'h0030, 16'h0, 3'd7);
    tick(); idle_inputs();
    check("ill_req", dmem_req, 0);
    check("ill_fault", mem_fault, 1);
    check("ill_wb_valid", wb_valid, 0);
    check("ill_in_ready", in_ready, 1);
    tick();
    check("ill_fault_pulse", mem_fault, 0);

    // Reset during WAIT abandons the access
    issue(1, 0, 16'h0050, 16'h0, 3'd2);
    tick(); idle_inputs();
    check("rw_req", dmem_req, 1);
    rst = 1;
    tick();
    rst = 0;
    check("rw_req_low", dmem_req, 0);
    check("rw_in_ready", in_ready, 1);
    check("rw_wb_valid", wb_valid, 0);
    check("rw_fault", mem_fault, 0);
    check("rw_addr", dmem_addr, 0);
    dmem_ready = 1;
    tick(); idle_inputs();
    check("rw_after_wb", wb_valid, 0);
    check("rw_after_fault", mem_fault, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_stage

`default_nettype wire
